// File: rtl/jump_target_unit.sv
// jump_target_unit: registered next-PC target generator for the multicycle MIPS datapath.
// Computes JUMP / BRANCH / REG / VECTOR targets from PC+4 and instruction fields with a
// one-cycle latency behind a valid/ready handshake.
//
// Optional feature macro: JTU_RAS_EN
//   defined   : circular return-address stack; JAL pushes, REG pops and flags ras_hit.
//   undefined : no stack storage, ras_hit tied to 0.
//
// Ports:
//   clk, reset            clock (rising edge), synchronous active-high reset
//   in_valid / in_ready   request handshake (in_ready is combinational)
//   mode                  00 JUMP, 01 BRANCH, 10 REG, 11 VECTOR
//   link                  JAL qualifier for JUMP mode
//   pc_in                 PC+4 of the instruction
//   inst_idx              instruction index / branch offset field
//   reg_in                rs value for REG mode
//   out_valid / out_ready result handshake
//   target                computed target
//   link_addr             pc_in of the accepted request
//   misaligned            low SHIFT bits of target nonzero
//   ras_hit               REG target matched the popped stack entry
module jump_target_unit #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned IDX_W = 26,
  parameter int unsigned BR_W = 16,
  parameter int unsigned SHIFT = 2,
  parameter logic [ADDR_W-1:0] VECTOR_ADDR = ADDR_W'(32'h0000_00FC),
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        mode,
  input  logic              link,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [IDX_W-1:0]  inst_idx,
  input  logic [ADDR_W-1:0] reg_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] link_addr,
  output logic              misaligned,
  output logic              ras_hit
);

  localparam logic [1:0] MODE_JUMP   = 2'b00;
  localparam logic [1:0] MODE_BRANCH = 2'b01;
  localparam logic [1:0] MODE_REG    = 2'b10;
  localparam logic [1:0] MODE_VECTOR = 2'b11;

  // Parameter sanity checks at elaboration
  if (ADDR_W <= IDX_W + SHIFT) begin : g_chk_addr
    $error("jump_target_unit: ADDR_W must exceed IDX_W+SHIFT");
  end
  if (BR_W > IDX_W) begin : g_chk_br
    $error("jump_target_unit: BR_W must not exceed IDX_W");
  end
  if (RAS_DEPTH < 2) begin : g_chk_ras
    $error("jump_target_unit: RAS_DEPTH must be at least 2");
  end
  if (SHIFT < 1) begin : g_chk_shift
    $error("jump_target_unit: SHIFT must be at least 1");
  end

  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic [ADDR_W-1:0] link_addr_q, link_addr_d;
  logic              misaligned_q, misaligned_d;

  logic              accept;
  logic [ADDR_W-1:0] target_c;
  logic [ADDR_W-1:0] br_ext;
  logic              hit_c;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Sign-extended, word-scaled branch offset
  assign br_ext = {{(ADDR_W-BR_W){inst_idx[BR_W-1]}}, inst_idx[BR_W-1:0]} << SHIFT;

  // Target selection for the request currently presented
  always_comb begin
    target_c = '0;
    case (mode)
      MODE_JUMP:   target_c = {pc_in[ADDR_W-1:IDX_W+SHIFT], inst_idx, {SHIFT{1'b0}}};
      MODE_BRANCH: target_c = pc_in + br_ext;
      MODE_REG:    target_c = reg_in;
      MODE_VECTOR: target_c = VECTOR_ADDR;
      default:     target_c = '0;
    endcase
  end

`ifdef JTU_RAS_EN
  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ras_hit_q, ras_hit_d;
  logic [PTR_W-1:0]  pop_idx;
  logic [PTR_W-1:0]  push_nxt;
  logic              push, pop;

  // ptr_q is the next write slot; the newest entry sits just below it
  assign pop_idx  = (ptr_q == '0) ? PTR_W'(RAS_DEPTH - 1) : ptr_q - PTR_W'(1);
  assign push_nxt = (ptr_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
  assign push     = accept && (mode == MODE_JUMP) && link;
  assign pop      = accept && (mode == MODE_REG) && (cnt_q != '0);
  assign hit_c    = pop && (ras_q[pop_idx] == reg_in);

  // Stack pointer/count update; full stack overwrites the oldest entry
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push) begin
      ptr_d = push_nxt;
      if (cnt_q != CNT_W'(RAS_DEPTH)) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop) begin
      ptr_d = pop_idx;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_comb begin
    ras_hit_d = ras_hit_q;
    if (accept) ras_hit_d = hit_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q     <= '0;
      cnt_q     <= '0;
      ras_hit_q <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      ras_hit_q <= ras_hit_d;
    end
  end

  // Stack storage; count gates validity so no reset is needed
  always_ff @(posedge clk) begin
    if (push && !reset) ras_q[ptr_q] <= pc_in;
  end

  assign ras_hit = ras_hit_q;
`else
  logic unused_link;
  assign unused_link = link;
  assign hit_c       = 1'b0;
  assign ras_hit     = 1'b0;
`endif

  // Output register next-state: load on accept, drain on consume, else hold
  always_comb begin
    out_valid_d  = out_valid_q;
    target_d     = target_q;
    link_addr_d  = link_addr_q;
    misaligned_d = misaligned_q;
    if (accept) begin
      out_valid_d  = 1'b1;
      target_d     = target_c;
      link_addr_d  = pc_in;
      misaligned_d = |target_c[SHIFT-1:0];
    end else if (out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      target_q     <= '0;
      link_addr_q  <= '0;
      misaligned_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      target_q     <= target_d;
      link_addr_q  <= link_addr_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign target     = target_q;
  assign link_addr  = link_addr_q;
  assign misaligned = misaligned_q;

endmodule

// File: tb/tb_jump_target_unit.sv
// Directed testbench for jump_target_unit (default parameters).
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_jump_target_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  mode;
  logic        link;
  logic [31:0] pc_in;
  logic [25:0] inst_idx;
  logic [31:0] reg_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] target;
  logic [31:0] link_addr;
  logic        misaligned;
  logic        ras_hit;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jump_target_unit dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .link      (link),
    .pc_in     (pc_in),
    .inst_idx  (inst_idx),
    .reg_in    (reg_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .target    (target),
    .link_addr (link_addr),
    .misaligned(misaligned),
    .ras_hit   (ras_hit)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [1:0] m, input logic l, input logic [31:0] pc,
                         input logic [25:0] idx, input logic [31:0] r);
    in_valid = 1'b1;
    mode     = m;
    link     = l;
    pc_in    = pc;
    inst_idx = idx;
    reg_in   = r;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    mode = 2'b00; link = 1'b0; pc_in = '0; inst_idx = '0; reg_in = '0;
    tick(); tick();
    checks++;
    if (out_valid !== 1'b0 || target !== 32'h0 || link_addr !== 32'h0 ||
        misaligned !== 1'b0 || ras_hit !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got v=%b t=%h l=%h m=%b h=%b, need all zero",
               out_valid, target, link_addr, misaligned, ras_hit);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_jump();
    set_req(2'b00, 1'b0, 32'hA000_0004, 26'h012_3456, 32'h0);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL jump_in_ready: got %b need 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || target !== 32'hA048_D158 || misaligned !== 1'b0 ||
        link_addr !== 32'hA000_0004 || ras_hit !== 1'b0) begin
      errors++;
      $display("FAIL jump_target: got v=%b t=%h m=%b l=%h, need v=1 t=a048d158 m=0 l=a0000004",
               out_valid, target, misaligned, link_addr);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || target !== 32'hA048_D158) begin
      errors++;
      $display("FAIL drain_hold: got v=%b t=%h, need v=0 t=a048d158", out_valid, target);
    end
  endtask

  task automatic test_branch();
    set_req(2'b01, 1'b0, 32'h0000_1000, 26'h3FF_FFFE, 32'h0);
    tick();
    checks++;
    if (out_valid !== 1'b1 || target !== 32'h0000_0FF8 || misaligned !== 1'b0) begin
      errors++;
      $display("FAIL branch_back: got v=%b t=%h, need v=1 t=00000ff8", out_valid, target);
    end
    // back-to-back: upper index bits must not leak into the offset
    set_req(2'b01, 1'b0, 32'h0000_1000, 26'h2AA_7FFF, 32'h0);
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || target !== 32'h0002_0FFC) begin
      errors++;
      $display("FAIL branch_fwd: got v=%b t=%h, need v=1 t=00020ffc", out_valid, target);
    end
    set_req(2'b01, 1'b0, 32'hFFFF_FFF0, 26'h000_0008, 32'h0);
    tick();
    in_valid = 1'b0;
    checks++;
    if (target !== 32'h0000_0010) begin
      errors++; $display("FAIL branch_wrap: got t=%h need 00000010", target);
    end
    tick();
  endtask

  task automatic test_reg_vector();
    set_req(2'b10, 1'b0, 32'h0000_0800, 26'h0, 32'h0000_0042);
    tick();
    checks++;
    if (target !== 32'h0000_0042 || misaligned !== 1'b1 || ras_hit !== 1'b0 ||
        link_addr !== 32'h0000_0800) begin
      errors++;
      $display("FAIL reg_target: got t=%h m=%b h=%b l=%h, need t=42 m=1 h=0 l=800",
               target, misaligned, ras_hit, link_addr);
    end
    set_req(2'b11, 1'b0, 32'h1234_5678, 26'h155_5555, 32'hDEAD_BEEF);
    tick();
    in_valid = 1'b0;
    checks++;
    if (target !== 32'h0000_00FC || misaligned !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL vector_target: got t=%h m=%b v=%b, need t=fc m=0 v=1",
               target, misaligned, out_valid);
    end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    set_req(2'b00, 1'b0, 32'h0000_0004, 26'h000_0010, 32'h0);
    tick();
    // second request waits while the first result is stalled
    set_req(2'b10, 1'b0, 32'h0, 26'h0, 32'h0000_0ABC);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || target !== 32'h0000_0040) begin
        errors++;
        $display("FAIL stall_%0d: got r=%b v=%b t=%h, need r=0 v=1 t=00000040",
                 i, in_ready, out_valid, target);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL release_ready: got %b need 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || target !== 32'h0000_0ABC) begin
      errors++;
      $display("FAIL release_result: got v=%b t=%h need v=1 t=00000abc", out_valid, target);
    end
    tick();
  endtask

  task automatic test_ras();
    logic [31:0] pcs [5];
    logic        exp_hit [5];
    pcs = '{32'h10, 32'h20, 32'h30, 32'h40, 32'h50};
`ifdef JTU_RAS_EN
    exp_hit = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`else
    exp_hit = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    set_req(2'b00, 1'b1, 32'h0000_0100, 26'h0, 32'h0);
    tick();
    set_req(2'b10, 1'b0, 32'h0, 26'h0, 32'h0000_0100);
    tick();
    in_valid = 1'b0;
    checks++;
`ifdef JTU_RAS_EN
    if (ras_hit !== 1'b1) begin
      errors++; $display("FAIL ras_single: got %b need 1", ras_hit);
    end
`else
    if (ras_hit !== 1'b0) begin
      errors++; $display("FAIL ras_single: got %b need 0", ras_hit);
    end
`endif
    for (int i = 0; i < 5; i++) begin
      set_req(2'b00, 1'b1, pcs[i], 26'h0, 32'h0);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      set_req(2'b10, 1'b0, 32'h0, 26'h0, pcs[4-i]);
      tick();
      checks++;
      if (ras_hit !== exp_hit[i] || target !== pcs[4-i]) begin
        errors++;
        $display("FAIL ras_pop_%0d: got h=%b t=%h need h=%b t=%h",
                 i, ras_hit, target, exp_hit[i], pcs[4-i]);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_stall();
    out_ready = 1'b0;
    set_req(2'b00, 1'b1, 32'h0000_0200, 26'h000_0001, 32'h0);
    tick();
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || target !== 32'h0 || link_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_stall: got v=%b t=%h l=%h need all zero", out_valid, target, link_addr);
    end
    out_ready = 1'b1;
    set_req(2'b10, 1'b0, 32'h0, 26'h0, 32'h0000_0200);
    tick();
    in_valid = 1'b0;
    checks++;
    if (ras_hit !== 1'b0 || out_valid !== 1'b1 || target !== 32'h0000_0200) begin
      errors++;
      $display("FAIL reset_ras_empty: got h=%b v=%b t=%h need h=0 v=1 t=00000200",
               ras_hit, out_valid, target);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_jump();
    test_branch();
    test_reg_vector();
    test_backpressure();
    test_ras();
    test_reset_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
